// File: rtl/mem_arb_pkg.sv
// Shared encodings for the icache/dcache main-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    typedef struct packed {
        req_id_t id;
        op_t     op;
    } txn_ctl_t;

    // Read and write both high resolves to a write.
    function automatic op_t req_op(input logic wr);
        return wr ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Grant select for the shared memory port: dcache first, icache forced through after MAX_D_STREAK dcache wins.
// Grants are combinational; the streak counter only moves on arbitration (IDLE) cycles.
module arb_priority_sel
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sample,
    input  logic i_req,
    input  logic d_req,
    output logic grant_i,
    output logic grant_d
);

    localparam int                  STREAK_W   = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    logic [STREAK_W-1:0] d_streak;
    logic                i_starved;

    always_comb begin
        i_starved = i_req && (d_streak == STREAK_MAX);
        grant_d   = sample && d_req && !i_starved;
        grant_i   = sample && i_req && !grant_d;
    end

    // Streak only counts dcache wins that actually made icache wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_streak <= '0;
        end else if (sample) begin
            if (grant_i || !i_req) begin
                d_streak <= '0;
            end else if (grant_d && (d_streak != STREAK_MAX)) begin
                d_streak <= d_streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between icache and dcache; one transaction at a time, IDLE -> ACCESS -> DONE.
// Latency 2 + memory wait cycles; requests are held levels, a stalled memory is aborted after TIMEOUT cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int LINE_W       = 64,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_readM,
    input  logic              i_writeM,
    input  logic [ADDR_W-1:0] i_addressM,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_readM,
    input  logic              d_writeM,
    input  logic [ADDR_W-1:0] d_addressM,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err,
    output logic              busy
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    state_t             state;
    state_t             state_nxt;
    txn_ctl_t           ctl;
    logic [TIMER_W-1:0] timer;
    logic               timed_out;
    logic               err_q;
    logic               i_req;
    logic               d_req;
    logic               grant_i;
    logic               grant_d;

    assign i_req     = i_readM || i_writeM;
    assign d_req     = d_readM || d_writeM;
    assign timed_out = (timer == TIMER_W'(TIMEOUT - 1));

    arb_priority_sel #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_sel (
        .clk     (clk),
        .reset   (reset),
        .sample  (state == IDLE),
        .i_req   (i_req),
        .d_req   (d_req),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_i || grant_d) state_nxt = ACCESS;
            ACCESS:  if (mem_ready || timed_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes and pulses decode from state only, so reset removes them without a clock.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        err       = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            ACCESS: begin
                mem_read  = (ctl.op == OP_READ);
                mem_write = (ctl.op == OP_WRITE);
            end
            DONE: begin
                i_done = (ctl.id == REQ_I);
                d_done = (ctl.id == REQ_D);
                err    = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl         <= '0;
            mem_address <= '0;
            mem_wdata   <= '0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            timer       <= '0;
            err_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_i || grant_d) begin
                        ctl.id      <= grant_d ? REQ_D : REQ_I;
                        ctl.op      <= grant_d ? req_op(d_writeM) : req_op(i_writeM);
                        mem_address <= grant_d ? d_addressM : i_addressM;
                        mem_wdata   <= grant_d ? d_wdata : i_wdata;
                        err_q       <= 1'b0;
                    end
                end
                ACCESS: begin
                    timer <= timer + 1'b1;
                    // A late mem_ready on the final cycle still counts as success.
                    if (mem_ready) begin
                        err_q <= 1'b0;
                        if (ctl.op == OP_READ) begin
                            if (ctl.id == REQ_D) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                i_rdata <= mem_rdata;
                            end
                        end
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                    end
                end
                DONE: begin
                    timer <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
